pcs_multilane_sync: RTL and testbench

//   Parametrised, multi-lane successor to the single-lane 1000BASE-X code-group synchronizer.
//   It runs one IEEE 802.3 Cl.36-style sync FSM per lane, with programmable acquire and lose thresholds.
//   It adds lane enables, an aggregate link flag and saturating per-lane loss-of-sync event counters.
//   It sits between the 10b deserializer/decoder and the Receive FSM, and drives SUDI/rx_even/sync_status per lane.

---
 rtl/pcs_sync_pkg.sv | 20 ++
 rtl/pcs_multilane_sync_if.sv | 26 ++
 rtl/pcs_sync_lane.sv | 156 +++++++++++++++
 rtl/pcs_multilane_sync.sv | 51 +++++
 tb/tb_pcs_multilane_sync.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_sync_pkg.sv
// Shared definitions for the multi-lane code-group synchronizer:
// FSM state encodings and the 7-bit comma patterns.
package pcs_sync_pkg;

  typedef enum logic [1:0] {
    LOSS      = 2'd0,
    COMMA_DET = 2'd1,
    ACQUIRE   = 2'd2,
    SYNC      = 2'd3
  } sync_state_t;

  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  // A comma is identified on the first seven bits (abcdeif) of the code-group.
  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_P) || (cg[9:3] == COMMA_N);
  endfunction

endpackage

// File: rtl/pcs_multilane_sync_if.sv
// Bundle of the per-lane receive-side signals between the decoder,
// the synchronizer and the Receive FSM.
interface pcs_multilane_sync_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
);
  logic [LANES-1:0]       lane_en;
  logic [LANES*10-1:0]    rx_code_group;
  logic [LANES-1:0]       rx_cg_err;
  logic                   los_clr;
  logic [LANES*10-1:0]    SUDI;
  logic [LANES-1:0]       rx_even;
  logic [LANES-1:0]       sync_status;
  logic                   all_sync;
  logic [LANES*CNT_W-1:0] los_count;

  modport master (
    output lane_en, rx_code_group, rx_cg_err, los_clr,
    input  SUDI, rx_even, sync_status, all_sync, los_count
  );

  modport slave (
    input  lane_en, rx_code_group, rx_cg_err, los_clr,
    output SUDI, rx_even, sync_status, all_sync, los_count
  );
endinterface

// File: rtl/pcs_sync_lane.sv
// One lane of code-group synchronization: sync FSM, comma/bad/good counters,
// the registered SUDI path and a saturating loss-of-sync event counter.
module pcs_sync_lane
  import pcs_sync_pkg::*;
#(
  parameter int COMMA_REQ = 3,
  parameter int GOOD_RUN  = 4,
  parameter int BAD_MAX   = 4,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [9:0]       i_cg,
  input  logic             i_err,
  input  logic             i_los_clr,
  output logic [9:0]       o_sudi,
  output logic             o_rx_even,
  output logic             o_sync,
  output logic [CNT_W-1:0] o_los_count
);

  localparam int CW = $clog2(COMMA_REQ + 1);
  localparam int BW = $clog2(BAD_MAX + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_REQ = CW'(COMMA_REQ);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [BW-1:0] B_MAX = BW'(BAD_MAX);
  localparam logic [GW-1:0] G_ONE = GW'(1);
  localparam logic [GW-1:0] G_RUN = GW'(GOOD_RUN);

  sync_state_t      r_state, w_state_next;
  logic             r_rx_even, w_rx_even_next;
  logic [CW-1:0]    r_comma_cnt, w_comma_cnt_next;
  logic [BW-1:0]    r_bad_cnt, w_bad_cnt_next;
  logic [GW-1:0]    r_good_cnt, w_good_cnt_next;
  logic [9:0]       r_sudi;
  logic [CNT_W-1:0] r_los_count;
  logic             w_los_inc;

  logic          w_comma, w_pos_even, w_cgbad, w_data;
  logic [CW-1:0] w_comma_inc;
  logic [BW-1:0] w_bad_inc, w_bad_dec;
  logic [GW-1:0] w_good_inc;

  assign w_comma     = is_comma(i_cg);
  assign w_pos_even  = ~r_rx_even;
  assign w_cgbad     = i_err | (w_comma & ~w_pos_even);
  assign w_data      = ~w_comma & ~i_err;
  assign w_comma_inc = r_comma_cnt + C_ONE;
  assign w_bad_inc   = r_bad_cnt + B_ONE;
  assign w_bad_dec   = r_bad_cnt - B_ONE;
  assign w_good_inc  = r_good_cnt + G_ONE;

  always_comb begin
    w_state_next     = r_state;
    w_rx_even_next   = ~r_rx_even;
    w_comma_cnt_next = r_comma_cnt;
    w_bad_cnt_next   = r_bad_cnt;
    w_good_cnt_next  = r_good_cnt;
    w_los_inc        = 1'b0;

    unique case (r_state)
      LOSS: begin
        if (w_comma) begin
          w_state_next     = COMMA_DET;
          w_rx_even_next   = 1'b1;
          w_comma_cnt_next = C_ONE;
        end
      end
      COMMA_DET: begin
        w_rx_even_next = 1'b0;
        if (w_data && (r_comma_cnt == C_REQ)) begin
          w_state_next    = SYNC;
          w_bad_cnt_next  = '0;
          w_good_cnt_next = '0;
        end else if (w_data) begin
          w_state_next = ACQUIRE;
        end else begin
          w_state_next = LOSS;
        end
      end
      ACQUIRE: begin
        if (w_comma && w_pos_even && !i_err) begin
          w_state_next     = COMMA_DET;
          w_comma_cnt_next = w_comma_inc;
        end else if (!w_data) begin
          w_state_next = LOSS;
        end
      end
      SYNC: begin
        if (w_cgbad) begin
          w_bad_cnt_next  = w_bad_inc;
          w_good_cnt_next = '0;
          if (w_bad_inc == B_MAX) begin
            w_state_next = LOSS;
            w_los_inc    = 1'b1;
          end
        end else if (r_bad_cnt != '0) begin
          // A full run of good code-groups forgives one outstanding bad one.
          if (w_good_inc == G_RUN) begin
            w_bad_cnt_next  = w_bad_dec;
            w_good_cnt_next = '0;
          end else begin
            w_good_cnt_next = w_good_inc;
          end
        end else begin
          w_good_cnt_next = '0;
        end
      end
      default: w_state_next = LOSS;
    endcase

    // A disabled lane parks in LOSS and is not reported as a loss event.
    if (!i_en) begin
      w_state_next     = LOSS;
      w_rx_even_next   = ~r_rx_even;
      w_comma_cnt_next = '0;
      w_bad_cnt_next   = '0;
      w_good_cnt_next  = '0;
      w_los_inc        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= LOSS;
      r_rx_even   <= 1'b0;
      r_comma_cnt <= '0;
      r_bad_cnt   <= '0;
      r_good_cnt  <= '0;
      r_sudi      <= '0;
      r_los_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rx_even   <= w_rx_even_next;
      r_comma_cnt <= w_comma_cnt_next;
      r_bad_cnt   <= w_bad_cnt_next;
      r_good_cnt  <= w_good_cnt_next;
      r_sudi      <= i_cg;
      if (i_los_clr) begin
        r_los_count <= '0;
      end else if (w_los_inc && (r_los_count != '1)) begin
        r_los_count <= r_los_count + 1'b1;
      end
    end
  end

  assign o_sudi      = r_sudi;
  assign o_rx_even   = r_rx_even;
  assign o_sync      = (r_state == SYNC);
  assign o_los_count = r_los_count;

endmodule

// File: rtl/pcs_multilane_sync.sv
// Multi-lane code-group synchronizer: independent per-lane sync FSMs plus an
// aggregate link flag over the enabled lanes.
module pcs_multilane_sync
  import pcs_sync_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int COMMA_REQ = 3,
  parameter int GOOD_RUN  = 4,
  parameter int BAD_MAX   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 GTX_CLK,
  input  logic                 mr_main_reset,
  pcs_multilane_sync_if.slave  io_bus
);

  logic [LANES*10-1:0]    w_sudi;
  logic [LANES-1:0]       w_rx_even;
  logic [LANES-1:0]       w_sync;
  logic [LANES*CNT_W-1:0] w_los_count;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pcs_sync_lane #(
        .COMMA_REQ (COMMA_REQ),
        .GOOD_RUN  (GOOD_RUN),
        .BAD_MAX   (BAD_MAX),
        .CNT_W     (CNT_W)
      ) u_lane (
        .i_clk       (GTX_CLK),
        .i_rst_n     (mr_main_reset),
        .i_en        (io_bus.lane_en[gi]),
        .i_cg        (io_bus.rx_code_group[gi*10 +: 10]),
        .i_err       (io_bus.rx_cg_err[gi]),
        .i_los_clr   (io_bus.los_clr),
        .o_sudi      (w_sudi[gi*10 +: 10]),
        .o_rx_even   (w_rx_even[gi]),
        .o_sync      (w_sync[gi]),
        .o_los_count (w_los_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign io_bus.SUDI        = w_sudi;
  assign io_bus.rx_even     = w_rx_even;
  assign io_bus.sync_status = w_sync;
  assign io_bus.los_count   = w_los_count;
  // Disabled lanes are ignored; with no lane enabled the link is reported down.
  assign io_bus.all_sync    = (|io_bus.lane_en) & (&(w_sync | ~io_bus.lane_en));

endmodule

// File: tb/tb_pcs_multilane_sync.sv
// Directed bench for pcs_multilane_sync: a 4-lane instance with default thresholds
// and a 1-lane instance with a 2-bit loss counter for saturation and clear priority.
module tb_pcs_multilane_sync;

  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b1001000101;
  localparam logic [9:0] D56  = 10'b1010010110;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pcs_multilane_sync_if #(.LANES(4), .CNT_W(8)) bus_a();
  pcs_multilane_sync_if #(.LANES(1), .CNT_W(2)) bus_b();

  pcs_multilane_sync #(
    .LANES(4), .COMMA_REQ(3), .GOOD_RUN(4), .BAD_MAX(4), .CNT_W(8)
  ) u_dut_a (
    .GTX_CLK       (clk),
    .mr_main_reset (rst_n),
    .io_bus        (bus_a)
  );

  pcs_multilane_sync #(
    .LANES(1), .COMMA_REQ(3), .GOOD_RUN(4), .BAD_MAX(4), .CNT_W(2)
  ) u_dut_b (
    .GTX_CLK       (clk),
    .mr_main_reset (rst_n),
    .io_bus        (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [9:0] c0, input logic [9:0] c1,
                         input logic [9:0] c2, input logic [9:0] c3,
                         input logic [3:0] err);
    bus_a.rx_code_group = {c3, c2, c1, c0};
    bus_a.rx_cg_err     = err;
  endtask

  function automatic logic [9:0] kd(input logic on, input int idx);
    if (!on) return D56;
    return (idx % 2 == 0) ? K285 : D162;
  endfunction

  task automatic kd_seq_a(input logic [3:0] m);
    for (int r = 0; r < 6; r++) begin
      drive_a(kd(m[0], r), kd(m[1], r), kd(m[2], r), kd(m[3], r), 4'b0000);
      tick();
    end
  endtask

  task automatic kd_seq_b();
    for (int r = 0; r < 6; r++) begin
      bus_b.rx_code_group = kd(1'b1, r);
      bus_b.rx_cg_err     = 1'b0;
      tick();
    end
  endtask

  task automatic errs_b(input int n);
    for (int i = 0; i < n; i++) begin
      bus_b.rx_code_group = D56;
      bus_b.rx_cg_err     = 1'b1;
      tick();
    end
    bus_b.rx_cg_err = 1'b0;
  endtask

  initial begin
    logic [9:0] err_pat;
    rst_n = 1'b0;
    bus_a.lane_en = 4'hF;
    bus_a.los_clr = 1'b0;
    drive_a(D56, D56, D56, D56, 4'b0000);
    bus_b.lane_en = 1'b1;
    bus_b.los_clr = 1'b0;
    bus_b.rx_code_group = D56;
    bus_b.rx_cg_err = 1'b0;

    // Reset: every output cleared.
    tick();
    tick();
    chk("rst_sudi", bus_a.SUDI, 40'h0);
    chk("rst_even", bus_a.rx_even, 4'h0);
    chk("rst_sync", bus_a.sync_status, 4'h0);
    chk("rst_all", bus_a.all_sync, 1'b0);
    chk("rst_los", bus_a.los_count, 32'h0);
    chk("rst_b_sudi", bus_b.SUDI, 10'h0);

    // Idle data without commas never synchronizes.
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("idle_sync", bus_a.sync_status, 4'h0);
    end
    chk("idle_sudi", bus_a.SUDI, {D56, D56, D56, D56});

    // Lane 0 acquires on three K28.5/D16.2 pairs.
    for (int r = 0; r < 6; r++) begin
      drive_a(kd(1'b1, r), D56, D56, D56, 4'b0000);
      tick();
      chk("acq_sudi0", bus_a.SUDI[9:0], kd(1'b1, r));
      chk("acq_even0", bus_a.rx_even[0], (r % 2 == 0));
      chk("acq_sync0", bus_a.sync_status[0], (r == 5));
      chk("acq_all", bus_a.all_sync, 1'b0);
    end

    // Remaining lanes acquire; all_sync rises with the last one.
    for (int r = 0; r < 6; r++) begin
      drive_a(D56, kd(1'b1, r), kd(1'b1, r), kd(1'b1, r), 4'b0000);
      tick();
      chk("acq_all3", bus_a.all_sync, (r == 5));
    end
    chk("acq_sync_all", bus_a.sync_status, 4'hF);

    // Four errors separated by short good runs: loss on the fourth.
    err_pat = 10'b1000100101;
    for (int r = 0; r < 10; r++) begin
      drive_a(D56, D56, D56, D56, {3'b000, err_pat[r]});
      tick();
      chk("err_sync0", bus_a.sync_status[0], (r != 9));
    end
    chk("err_los0", bus_a.los_count[7:0], 8'd1);
    chk("err_sync", bus_a.sync_status, 4'b1110);
    chk("err_all", bus_a.all_sync, 1'b0);

    kd_seq_a(4'b0001);
    chk("resync_all", bus_a.all_sync, 1'b1);

    // Error followed by a full forgiving run keeps the lane in sync.
    for (int rep = 0; rep < 10; rep++) begin
      for (int k = 0; k < 5; k++) begin
        drive_a(D56, D56, D56, D56, {3'b000, (k == 0)});
        tick();
      end
      chk("forgive_sync0", bus_a.sync_status[0], 1'b1);
    end
    chk("forgive_los0", bus_a.los_count[7:0], 8'd1);

    // Commas at odd positions count as bad code-groups.
    chk("odd_pre_even", bus_a.rx_even[0], 1'b0);
    for (int r = 0; r < 8; r++) begin
      drive_a((r % 2 == 1) ? K285 : D56, D56, D56, D56, 4'b0000);
      tick();
      chk("odd_even0", bus_a.rx_even[0], (r % 2 == 0));
      chk("odd_sync0", bus_a.sync_status[0], (r != 7));
    end
    chk("odd_los0", bus_a.los_count[7:0], 8'd2);

    kd_seq_a(4'b0001);
    chk("resync2", bus_a.sync_status, 4'hF);

    // Disable lane 2 while synced.
    bus_a.lane_en = 4'b1011;
    drive_a(D56, D56, D56, D56, 4'b0000);
    tick();
    chk("dis_sync", bus_a.sync_status, 4'b1011);
    chk("dis_los2", bus_a.los_count[23:16], 8'd0);
    chk("dis_all", bus_a.all_sync, 1'b1);
    chk("dis_sudi2", bus_a.SUDI[29:20], D56);
    bus_a.lane_en = 4'hF;
    tick();
    chk("reen_all", bus_a.all_sync, 1'b0);
    chk("reen_sync", bus_a.sync_status, 4'b1011);

    // Reset in the middle of ACQUIRE on lane 2.
    drive_a(D56, D56, K285, D56, 4'b0000);
    tick();
    drive_a(D56, D56, D162, D56, 4'b0000);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sudi", bus_a.SUDI, 40'h0);
    chk("mid_rst_even", bus_a.rx_even, 4'h0);
    chk("mid_rst_sync", bus_a.sync_status, 4'h0);
    chk("mid_rst_all", bus_a.all_sync, 1'b0);
    chk("mid_rst_los", bus_a.los_count, 32'h0);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      drive_a(D56, D56, kd(1'b1, r), D56, 4'b0000);
      tick();
    end
    chk("post_rst_sync2", bus_a.sync_status[2], 1'b0);
    for (int r = 4; r < 6; r++) begin
      drive_a(D56, D56, kd(1'b1, r), D56, 4'b0000);
      tick();
    end
    chk("post_rst_sync2b", bus_a.sync_status[2], 1'b1);

    // Narrow counter saturates at 3.
    drive_a(D56, D56, D56, D56, 4'b0000);
    for (int k = 1; k <= 5; k++) begin
      kd_seq_b();
      chk("sat_sync", bus_b.sync_status, 1'b1);
      errs_b(4);
      chk("sat_los", bus_b.los_count, (k > 3) ? 2'd3 : 2'(k));
      chk("sat_lost", bus_b.sync_status, 1'b0);
    end

    // Clear wins over a simultaneous loss event.
    kd_seq_b();
    errs_b(3);
    chk("clr_presync", bus_b.sync_status, 1'b1);
    bus_b.los_clr = 1'b1;
    bus_b.rx_cg_err = 1'b1;
    tick();
    bus_b.los_clr = 1'b0;
    bus_b.rx_cg_err = 1'b0;
    chk("clr_los", bus_b.los_count, 2'd0);
    chk("clr_sync", bus_b.sync_status, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
